mips_io_ports: RTL and testbench

MIPS_IO_PORTS -- requirements
Module: mips_io_ports

---
 rtl/mips_io_ports.sv | 151 +++++++++++++++
 tb/tb_mips_io_ports.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_io_ports.sv
// Memory-mapped I/O port block: OUT/IN channel registers, change-status flags
// with write-one-to-clear, and an optional masked interrupt (macro IO_IRQ_EN).
module mips_io_ports #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned IN_WIDTH  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          MemWrite,
  input  logic                          MemRead,
  input  logic [31:0]                   Address,
  input  logic [31:0]                   WriteData,
  output logic [31:0]                   ReadData,
  output logic                          Select,
  input  logic [NUM_PORTS*IN_WIDTH-1:0] PortIn,
  output logic [NUM_PORTS*32-1:0]       PortOut,
  output logic                          Irq
);

  localparam int unsigned IDX_W      = 3;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0040;
  localparam logic [31:0] OFF_MASK   = 32'h0000_0044;

  logic [31:0]          w_off;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_aligned;
  logic                 w_idx_ok;
  logic                 w_is_out;
  logic                 w_is_in;
  logic                 w_is_status;
  logic                 w_is_mask;
  logic [NUM_PORTS-1:0] w_set;
  logic [NUM_PORTS-1:0] w_clr;
  logic [31:0]          w_rdata;

  logic [31:0]          r_out    [NUM_PORTS];
  logic [IN_WIDTH-1:0]  r_s0     [NUM_PORTS];
  logic [IN_WIDTH-1:0]  r_s1     [NUM_PORTS];
  logic [IN_WIDTH-1:0]  r_cap    [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_status;

  // Address decode relative to the window base; misaligned offsets never hit
  assign w_off       = Address - BASE_ADDR;
  assign w_idx       = w_off[4:2];
  assign w_aligned   = (w_off[1:0] == 2'b00);
  assign w_idx_ok    = (32'(w_idx) < NUM_PORTS);
  assign w_is_out    = (w_off[31:5] == 27'd0) && w_aligned && w_idx_ok;
  assign w_is_in     = (w_off[31:5] == 27'd1) && w_aligned && w_idx_ok;
  assign w_is_status = (w_off == OFF_STATUS);
  assign w_is_mask   = (w_off == OFF_MASK);
  assign Select      = w_is_out | w_is_in | w_is_status | w_is_mask;

  // Change detect against the captured value; clear mask from a STATUS write
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_set[i] = (r_s1[i] != r_cap[i]);
    end
    if (MemWrite && w_is_status) begin
      w_clr = WriteData[NUM_PORTS-1:0];
    end
  end

  // Input synchronizers, capture registers and sticky status (set beats clear)
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        r_s0[i]  <= '0;
        r_s1[i]  <= '0;
        r_cap[i] <= '0;
      end
      r_status <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        r_s0[i]  <= PortIn[i*IN_WIDTH +: IN_WIDTH];
        r_s1[i]  <= r_s0[i];
        r_cap[i] <= r_s1[i];
      end
      r_status <= (r_status & ~w_clr) | w_set;
    end
  end

  // Output channel registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        r_out[i] <= '0;
      end
    end else if (MemWrite && w_is_out) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (w_idx == IDX_W'(i)) begin
          r_out[i] <= WriteData;
        end
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_PORTS); g++) begin : g_port_out
    assign PortOut[g*32 +: 32] = r_out[g];
  end

`ifdef IO_IRQ_EN
  logic [NUM_PORTS-1:0] r_mask;
  logic                 r_irq;

  // Interrupt mask and registered level interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (MemWrite && w_is_mask) begin
        r_mask <= WriteData[NUM_PORTS-1:0];
      end
      r_irq <= |(r_status & r_mask);
    end
  end

  assign Irq = r_irq;
`else
  assign Irq = 1'b0;
`endif

  // Combinational read mux; returns the pre-edge value on read+write
  always_comb begin
    w_rdata = 32'h0;
    if (MemRead && Select) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (w_is_out && (w_idx == IDX_W'(i))) begin
          w_rdata = r_out[i];
        end
        if (w_is_in && (w_idx == IDX_W'(i))) begin
          w_rdata = 32'(r_cap[i]);
        end
      end
      if (w_is_status) begin
        w_rdata = 32'(r_status);
      end
`ifdef IO_IRQ_EN
      if (w_is_mask) begin
        w_rdata = 32'(r_mask);
      end
`endif
    end
  end

  assign ReadData = w_rdata;

endmodule

// File: tb/tb_mips_io_ports.sv
// Self-checking bench for mips_io_ports: directed vector table, hand-written
// flag/interrupt sequences and randomized traffic against a history-based model.
module tb_mips_io_ports;

  localparam int unsigned N    = 4;
  localparam int unsigned W    = 8;
  localparam logic [31:0] BASE = 32'h1001_0000;
`ifdef IO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           MemWrite = 1'b0;
  logic           MemRead = 1'b0;
  logic [31:0]    Address = 32'h0;
  logic [31:0]    WriteData = 32'h0;
  logic [31:0]    ReadData;
  logic           Select;
  logic [N*W-1:0] PortIn = '0;
  logic [N*32-1:0] PortOut;
  logic           Irq;

  int n_total = 0;
  int n_bad   = 0;

  mips_io_ports #(.NUM_PORTS(N), .IN_WIDTH(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .Select(Select), .PortIn(PortIn), .PortOut(PortOut), .Irq(Irq)
  );

  always #5 clk = ~clk;

  // Model: OUT values, the PortIn values seen 1/2/3 edges ago, flags, mask, irq
  logic [31:0]  m_out [N];
  logic [W-1:0] m_hist [3][N];
  logic [N-1:0] m_status;
  logic [N-1:0] m_mask;
  logic         m_irq;

  typedef struct {
    bit          rst, we, re;
    logic [31:0] a, wd, pin;
    bit          sel;
    logic [31:0] rd, po1;
  } vec_t;

  vec_t        tv [18];
  logic [31:0] offs [18];

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit is_hit(input logic [31:0] a);
    logic [31:0] off = a - BASE;
    if (off % 4 != 0) return 1'b0;
    return (off < 4*N) || (off >= 32 && off < 32 + 4*N) || off == 64 || off == 68;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a, input bit re);
    logic [31:0] off = a - BASE;
    int idx;
    if (!re || !is_hit(a)) return 32'h0;
    if (off < 32) begin idx = int'(off / 4); return m_out[idx]; end
    if (off < 64) begin idx = int'((off - 32) / 4); return 32'(m_hist[2][idx]); end
    if (off == 64) return 32'(m_status);
    return IRQ_EN ? 32'(m_mask) : 32'h0;
  endfunction

  task automatic model_check();
    logic [N*32-1:0] po;
    for (int i = 0; i < N; i++) po[i*32 +: 32] = m_out[i];
    chk("select", 256'(Select), 256'(is_hit(Address)));
    chk("readdata", 256'(ReadData), 256'(exp_read(Address, MemRead)));
    chk("portout", 256'(PortOut), 256'(po));
    chk("irq", 256'(Irq), 256'(m_irq));
  endtask

  task automatic model_edge();
    logic [31:0] off = Address - BASE;
    logic        irq_n;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_out[i] = '0;
        for (int k = 0; k < 3; k++) m_hist[k][i] = '0;
      end
      m_status = '0; m_mask = '0; m_irq = 1'b0;
    end else begin
      irq_n = IRQ_EN && ((m_status & m_mask) != 0);
      for (int i = 0; i < N; i++) begin
        if (m_hist[1][i] != m_hist[2][i]) m_status[i] = 1'b1;
        else if (MemWrite && off == 64 && WriteData[i]) m_status[i] = 1'b0;
      end
      if (MemWrite && is_hit(Address) && off < 32) m_out[int'(off / 4)] = WriteData;
      if (MemWrite && off == 68 && IRQ_EN) m_mask = WriteData[N-1:0];
      for (int i = 0; i < N; i++) begin
        m_hist[2][i] = m_hist[1][i];
        m_hist[1][i] = m_hist[0][i];
        m_hist[0][i] = PortIn[i*W +: W];
      end
      m_irq = irq_n;
    end
  endtask

  task automatic apply(input bit rst, input bit we, input bit re, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] pin);
    @(negedge clk);
    reset = rst; MemWrite = we; MemRead = re; Address = a; WriteData = wd;
    PortIn = (N*W)'(pin);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
  endtask

  task automatic cyc(input bit rst, input bit we, input bit re, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] pin);
    apply(rst, we, re, a, wd, pin);
    model_check();
    tick();
  endtask

  function automatic vec_t mk(bit rst, bit we, bit re, logic [31:0] off, logic [31:0] wd,
                              bit sel, logic [31:0] rd, logic [31:0] po1);
    vec_t v;
    v.rst = rst; v.we = we; v.re = re; v.a = BASE + off; v.wd = wd; v.pin = 32'h0;
    v.sel = sel; v.rd = rd; v.po1 = po1;
    return v;
  endfunction

  initial begin
    // Directed table: reset reads, OUT[1] write/readback, unmapped and RO writes
    tv[0]  = mk(1, 0, 1, 32'h40, 32'h0,          1, 32'h0,          32'h0);
    tv[1]  = mk(0, 0, 1, 32'h00, 32'h0,          1, 32'h0,          32'h0);
    tv[2]  = mk(0, 0, 1, 32'h20, 32'h0,          1, 32'h0,          32'h0);
    tv[3]  = mk(0, 0, 1, 32'h44, 32'h0,          1, 32'h0,          32'h0);
    tv[4]  = mk(0, 0, 1, 32'h0C, 32'h0,          1, 32'h0,          32'h0);
    tv[5]  = mk(0, 1, 0, 32'h04, 32'hDEAD_BEEF,  1, 32'h0,          32'h0);
    tv[6]  = mk(0, 0, 1, 32'h04, 32'h0,          1, 32'hDEAD_BEEF,  32'hDEAD_BEEF);
    tv[7]  = mk(0, 0, 1, 32'h00, 32'h0,          1, 32'h0,          32'hDEAD_BEEF);
    tv[8]  = mk(0, 1, 1, 32'h04, 32'h1234_5678,  1, 32'hDEAD_BEEF,  32'hDEAD_BEEF);
    tv[9]  = mk(0, 0, 1, 32'h04, 32'h0,          1, 32'h1234_5678,  32'h1234_5678);
    tv[10] = mk(0, 1, 1, 32'h48, 32'hFFFF_FFFF,  0, 32'h0,          32'h1234_5678);
    tv[11] = mk(0, 1, 1, 32'h20, 32'hFFFF_FFFF,  1, 32'h0,          32'h1234_5678);
    tv[12] = mk(0, 1, 1, 32'h02, 32'hFFFF_FFFF,  0, 32'h0,          32'h1234_5678);
    tv[13] = mk(0, 1, 1, 32'h10, 32'hFFFF_FFFF,  0, 32'h0,          32'h1234_5678);
    tv[14] = mk(0, 0, 1, 32'h30, 32'h0,          0, 32'h0,          32'h1234_5678);
    tv[15] = mk(0, 0, 1, 32'h04, 32'h0,          1, 32'h1234_5678,  32'h1234_5678);
    tv[16] = mk(1, 1, 1, 32'h04, 32'hAAAA_AAAA,  1, 32'h1234_5678,  32'h1234_5678);
    tv[17] = mk(0, 0, 1, 32'h04, 32'h0,          1, 32'h0,          32'h0);

    offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h1C, 32'h20, 32'h24, 32'h2C,
             32'h30, 32'h40, 32'h44, 32'h48, 32'h41, 32'h02, 32'h3C, 32'hFFFF_FFFC, 32'h42};

    // Two reset cycles before any outputs are defined
    for (int c = 0; c < 2; c++) begin
      apply(1, 0, 0, BASE, 32'h0, 32'h0);
      tick();
    end
    chk("reset_portout", 256'(PortOut), 256'(0));
    chk("reset_irq", 256'(Irq), 256'(0));

    for (int v = 0; v < 18; v++) begin
      apply(tv[v].rst, tv[v].we, tv[v].re, tv[v].a, tv[v].wd, tv[v].pin);
      chk($sformatf("tv%0d_sel", v), 256'(Select), 256'(tv[v].sel));
      chk($sformatf("tv%0d_rd", v), 256'(ReadData), 256'(tv[v].rd));
      chk($sformatf("tv%0d_po1", v), 256'(PortOut[63:32]), 256'(tv[v].po1));
      chk($sformatf("tv%0d_po_other", v), 256'({PortOut[127:64], PortOut[31:0]}), 256'(0));
      model_check();
      tick();
    end

    // Input change latency and interrupt timing
    cyc(0, 1, 0, BASE + 32'h44, 32'h1, 32'h0);
    apply(0, 0, 1, BASE + 32'h20, 32'h0, 32'h3); chk("lat_k", 256'(ReadData), 256'(0)); model_check(); tick();
    apply(0, 0, 1, BASE + 32'h20, 32'h0, 32'h3); chk("lat_k1", 256'(ReadData), 256'(0)); model_check(); tick();
    apply(0, 0, 1, BASE + 32'h40, 32'h0, 32'h3); chk("stat_k1", 256'(ReadData), 256'(0)); model_check(); tick();
    apply(0, 0, 1, BASE + 32'h20, 32'h0, 32'h3); chk("in0_k2", 256'(ReadData), 256'(3));
    chk("irq_k2", 256'(Irq), 256'(0)); model_check(); tick();
    apply(0, 0, 1, BASE + 32'h40, 32'h0, 32'h3); chk("stat_k3", 256'(ReadData), 256'(1));
    chk("irq_k3", 256'(Irq), 256'(IRQ_EN)); model_check(); tick();

    // Set and W1C in the same cycle: set wins; then plain clear
    cyc(0, 0, 0, BASE, 32'h0, 32'h5);
    cyc(0, 0, 0, BASE, 32'h0, 32'h5);
    cyc(0, 1, 0, BASE + 32'h40, 32'h1, 32'h5);
    apply(0, 1, 1, BASE + 32'h40, 32'h1, 32'h5); chk("w1c_setwins", 256'(ReadData), 256'(1)); model_check(); tick();
    apply(0, 0, 1, BASE + 32'h40, 32'h0, 32'h5); chk("w1c_clr", 256'(ReadData), 256'(0));
    chk("w1c_irq_lag", 256'(Irq), 256'(IRQ_EN)); model_check(); tick();
    apply(0, 0, 0, BASE, 32'h0, 32'h5); chk("w1c_irq_off", 256'(Irq), 256'(0)); model_check(); tick();

    // Reset discards an in-flight synchronizer sample
    cyc(0, 0, 0, BASE, 32'h0, 32'h9);
    cyc(1, 0, 0, BASE, 32'h0, 32'h0);
    for (int c = 0; c < 4; c++) cyc(0, 0, 0, BASE, 32'h0, 32'h0);
    apply(0, 0, 1, BASE + 32'h40, 32'h0, 32'h0); chk("rst_inflight", 256'(ReadData), 256'(0)); model_check(); tick();

    // Mask readback and interrupt depend on the build option
    cyc(0, 1, 0, BASE + 32'h44, 32'hF, 32'h0);
    apply(0, 0, 1, BASE + 32'h44, 32'h0, 32'h1); chk("mask_rd", 256'(ReadData), 256'(IRQ_EN ? 32'hF : 32'h0));
    chk("mask_sel", 256'(Select), 256'(1)); model_check(); tick();
    cyc(0, 0, 0, BASE, 32'h0, 32'h1);
    cyc(0, 0, 0, BASE, 32'h0, 32'h1);
    apply(0, 0, 1, BASE + 32'h40, 32'h0, 32'h1); chk("opt_stat", 256'(ReadData), 256'(1)); model_check(); tick();
    apply(0, 0, 0, BASE, 32'h0, 32'h1); chk("opt_irq", 256'(Irq), 256'(IRQ_EN)); model_check(); tick();

    // Randomized traffic against the model
    begin
      logic [31:0] pin = 32'h1;
      for (int c = 0; c < 800; c++) begin
        logic [31:0] a;
        if ($urandom_range(0, 3) == 0) pin = $urandom;
        a = ($urandom_range(0, 15) == 0) ? $urandom : BASE + offs[$urandom_range(0, 17)];
        cyc($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
            a, ($urandom_range(0, 1) == 1) ? $urandom : 32'(1 << $urandom_range(0, 3)), pin);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
